// File: rtl/adc_frame_packer_pkg.sv
// Shared types and constants for the ADC frame packer.
package adc_frame_packer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    TS      = 2'd2,
    TRAILER = 2'd3
  } state_t;

  typedef struct packed {
    logic [7:0]  magic;
    logic [7:0]  seq;
    logic        short_f;
    logic [14:0] count;
  } trailer_t;

  localparam logic [3:0] TRAILER_KEEP = 4'hF;
  localparam int         CNT_W        = 15;
  localparam int         SEQ_W        = 8;

  // Assemble the 32-bit trailer word from its fields.
  function automatic logic [31:0] pack_trailer(
    input logic [7:0]       magic,
    input logic [SEQ_W-1:0] seq,
    input logic             short_f,
    input logic [CNT_W-1:0] count
  );
    trailer_t t;
    t.magic   = magic;
    t.seq     = seq;
    t.short_f = short_f;
    t.count   = count;
    return t;
  endfunction

endpackage

// File: rtl/adc_frame_packer_axis_out_reg.sv
// One-entry valid/ready output register. Owns the downstream AXI-Stream
// signals and tells the FSM when a new word may be loaded.
module axis_out_reg (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [31:0] i_data,
  input  logic [3:0]  i_keep,
  input  logic        i_last,
  input  logic        i_tready,
  output logic [31:0] o_tdata,
  output logic [3:0]  o_tkeep,
  output logic        o_tlast,
  output logic        o_tvalid,
  output logic        o_can_load
);

  logic [31:0] r_data;
  logic [3:0]  r_keep;
  logic        r_last;
  logic        r_valid;

  // Load a new word when asked; otherwise drop valid once it is taken.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_keep  <= i_keep;
      r_last  <= i_last;
      r_valid <= 1'b1;
    end else if (i_tready) begin
      r_valid <= 1'b0;
    end
  end

  // Empty, or draining this cycle: a load never overwrites a held word.
  assign o_can_load = !r_valid || i_tready;
  assign o_tdata    = r_data;
  assign o_tkeep    = r_keep;
  assign o_tlast    = r_last;
  assign o_tvalid   = r_valid;

endmodule

// File: rtl/adc_frame_packer.sv
// ADC frame packer: cuts the 32-bit ADC sample-pair stream into packets of
// at most PKT_WORDS payload beats, each closed by a status trailer (tlast).
// Optional feature macro: ADC_PACKER_TIMESTAMP_EN adds a per-packet
// timestamp word (cycle count at the first payload beat) before the trailer.
//
//  state   | meaning
//  IDLE    | waiting for en and the first beat of a packet
//  PAYLOAD | forwarding payload beats, counting them
//  TS      | emitting the captured timestamp word (macro builds only)
//  TRAILER | emitting the status trailer, then back to IDLE
module adc_frame_packer
  import adc_frame_packer_pkg::*;
#(
  parameter int         PKT_WORDS = 1024,
  parameter logic [7:0] MAGIC     = 8'hA5
) (
  input  logic        s00_axis_aclk,
  input  logic        s00_axis_aresetn,
  input  logic        en,
  input  logic [31:0] s00_axis_tdata,
  input  logic [3:0]  s00_axis_tkeep,
  input  logic        s00_axis_tlast,
  input  logic        s00_axis_tvalid,
  output logic        s00_axis_tready,
  output logic [31:0] m00_axis_tdata,
  output logic [3:0]  m00_axis_tkeep,
  output logic        m00_axis_tlast,
  output logic        m00_axis_tvalid,
  input  logic        m00_axis_tready,
  output logic        busy
);

  localparam logic [CNT_W-1:0] PKT_LIM = CNT_W'(PKT_WORDS);

`ifdef ADC_PACKER_TIMESTAMP_EN
  localparam state_t END_STATE = TS;
`else
  localparam state_t END_STATE = TRAILER;
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [SEQ_W-1:0] r_seq;
  logic [SEQ_W-1:0] w_seq_nxt;
  logic             r_short;
  logic             w_short_nxt;
  logic             r_run;

  logic             w_load;
  logic [31:0]      w_ld_data;
  logic [3:0]       w_ld_keep;
  logic             w_ld_last;
  logic             w_can_load;
  logic             w_s_tready;
  logic             w_first;

  axis_out_reg u_out (
    .i_clk      (s00_axis_aclk),
    .i_rst_n    (s00_axis_aresetn),
    .i_load     (w_load),
    .i_data     (w_ld_data),
    .i_keep     (w_ld_keep),
    .i_last     (w_ld_last),
    .i_tready   (m00_axis_tready),
    .o_tdata    (m00_axis_tdata),
    .o_tkeep    (m00_axis_tkeep),
    .o_tlast    (m00_axis_tlast),
    .o_tvalid   (m00_axis_tvalid),
    .o_can_load (w_can_load)
  );

`ifdef ADC_PACKER_TIMESTAMP_EN
  logic [31:0] r_ts_cnt;
  logic [31:0] r_ts_cap;

  // Free-running cycle counter; snapshot taken on each packet's first beat.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_ts_cnt <= '0;
      r_ts_cap <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + 32'd1;
      if (w_first) r_ts_cap <= r_ts_cnt;
    end
  end
`endif

  // Keeps input ready low for the first cycle after reset even if en is high.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) r_run <= 1'b0;
    else                   r_run <= 1'b1;
  end

  // State, beat count, sequence number and short flag registers.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_state <= IDLE;
      r_count <= '0;
      r_seq   <= '0;
      r_short <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_seq   <= w_seq_nxt;
      r_short <= w_short_nxt;
    end
  end

  // Count is always 0 in IDLE, so the same increment yields 1 for a first beat.
  assign w_cnt_inc = r_count + CNT_W'(1);

  // Next-state logic and output-register load selection.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_seq_nxt   = r_seq;
    w_short_nxt = r_short;
    w_load      = 1'b0;
    w_ld_data   = s00_axis_tdata;
    w_ld_keep   = s00_axis_tkeep;
    w_ld_last   = 1'b0;
    w_s_tready  = 1'b0;
    w_first     = 1'b0;
    case (r_state)
      IDLE, PAYLOAD: begin
        w_s_tready = r_run && ((r_state == PAYLOAD) || en) && w_can_load;
        if (s00_axis_tvalid && w_s_tready) begin
          w_load      = 1'b1;
          w_count_nxt = w_cnt_inc;
          w_first     = (r_state == IDLE);
          if ((w_cnt_inc == PKT_LIM) || s00_axis_tlast) begin
            w_short_nxt = s00_axis_tlast;
            w_state_nxt = END_STATE;
          end else begin
            w_state_nxt = PAYLOAD;
          end
        end
      end
`ifdef ADC_PACKER_TIMESTAMP_EN
      TS: begin
        if (w_can_load) begin
          w_load      = 1'b1;
          w_ld_data   = r_ts_cap;
          w_ld_keep   = TRAILER_KEEP;
          w_state_nxt = TRAILER;
        end
      end
`endif
      TRAILER: begin
        if (w_can_load) begin
          w_load      = 1'b1;
          w_ld_data   = pack_trailer(MAGIC, r_seq, r_short, r_count);
          w_ld_keep   = TRAILER_KEEP;
          w_ld_last   = 1'b1;
          w_seq_nxt   = r_seq + SEQ_W'(1);
          w_count_nxt = '0;
          w_short_nxt = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign s00_axis_tready = w_s_tready;
  assign busy            = (r_state != IDLE) || m00_axis_tvalid;

endmodule
